// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver with a first-word-fall-through byte FIFO, a valid/ready
//   output stream and RTS hardware flow control. Single clock domain.
//
// Ports
//   clk        design clock
//   rst        synchronous active-high reset
//   rxd        asynchronous UART receive line (idle high)
//   rts        flow control, active-low: 0 = host may send, 1 = host must pause
//   m_data     FIFO head byte (0x00 while empty)
//   m_valid    m_data holds a valid byte
//   m_ready    consumer accepts the head byte
//   fill       current FIFO occupancy
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   overrun    sticky; set when a received byte is dropped on a full FIFO
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int RTS_THRESH   = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic                          rts,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   RTS_LVL   = (AW+1)'(RTS_THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------------------
  // rxd synchroniser; both flops reset to the idle level so a reset never
  // looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            bit_tick;
  logic            push_req;
  logic            stop_bad;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    bit_tick = 1'b0;
    push_req = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        // Mid-start-bit check: a line that is high again was only a glitch.
        if (cnt_q == HALF_LAST) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          bit_tick = 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          if (rx_s) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // Hold off until the line returns high so a break is not re-read
        // as a stream of start bits.
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counter restarts on every state change and on each bit period end.
      if (state_d != state_q || cnt_q == BIT_LAST) cnt_q <= '0;
      else                                         cnt_q <= cnt_q + 1'b1;
      if (state_d == S_DATA && state_q != S_DATA) bit_idx_q <= '0;
      else if (bit_tick)                          bit_idx_q <= bit_idx_q + 3'd1;
      // LSB arrives first, so shift in from the top.
      if (bit_tick) shift_q <= {rx_s, shift_q[7:1]};
      frame_err <= stop_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop;
  logic          full;
  logic          wr_en;

  assign m_valid = (fill != '0);
  assign pop     = m_valid && m_ready;
  assign full    = (fill == FULL_LVL);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en   = push_req && (!full || pop);
  assign m_data  = m_valid ? mem[rd_ptr] : 8'h00;

  // NOTE: storage is deliberately not reset; only pointers and fill are, and
  // m_data is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      overrun <= 1'b0;
      rts     <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (push_req && full && !pop) overrun <= 1'b1;
      rts <= (fill >= RTS_LVL);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. Bytes expected on the output stream are
// queued when their frames are issued; a negedge monitor pops and compares on
// every m_valid && m_ready handshake.
module tb_uart_rx_fifo;

  localparam int CPB    = 16;
  localparam int DEPTH  = 16;
  localparam int THRESH = 12;
  localparam int FW     = $clog2(DEPTH) + 1;
  // Posedges from the one that launches the start bit to the one at which the
  // byte is pushed: two synchroniser flops, one IDLE detect cycle, half a bit,
  // eight data bits and the stop bit.
  localparam int PUSH_EDGE = 2 + 1 + CPB / 2 + 9 * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic          rts;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [FW-1:0] fill;
  logic          frame_err;
  logic          overrun;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .RTS_THRESH  (THRESH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rts      (rts),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .fill     (fill),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ferr_pulses = 0;
  int         ferr0;
  logic [7:0] exp_q[$];
  bit         exp_overrun = 1'b0;
  bit         done;
  logic [7:0] rb;
  logic [7:0] t1_bytes [2] = '{8'hA5, 8'h3C};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted byte must be the oldest expected one.
  always @(negedge clk) begin
    if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", m_data, $time);
      end else begin
        check("rx_byte", m_data, exp_q.pop_front());
      end
    end
    if (frame_err === 1'b1) ferr_pulses++;
  end

  // Reference model: a byte is kept if the FIFO has room or a pop coincides.
  task automatic send_expect(input logic [7:0] b, input bit pop_same_cycle);
    if (exp_q.size() < DEPTH || pop_same_cycle) exp_q.push_back(b);
    else                                       exp_overrun = 1'b1;
  endtask

  // One 8N1 frame; the line is left at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rxd = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1 rxd = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_expect(b, 1'b0);
    send_frame(b, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fill", fill, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 8'h00);
    check("rst_rts", rts, 1);
    check("rst_ferr", frame_err, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk); #1 rst = 1'b0; m_ready = 1'b1;

    // 1: two clean frames, push visible exactly the cycle after the stop sample
    for (int i = 0; i < 2; i++) begin
      send_expect(t1_bytes[i], 1'b0);
      fork
        send_frame(t1_bytes[i], 1'b1);
        begin
          repeat (PUSH_EDGE) @(posedge clk);
          @(negedge clk);
          check("t1_valid_before_push", m_valid, 0);
          @(negedge clk);
          check("t1_valid_after_push", m_valid, 1);
          check("t1_data", m_data, t1_bytes[i]);
          check("t1_rts", rts, 0);
        end
      join
    end
    wait_drain("t1");
    check("t1_no_ferr", ferr_pulses, 0);

    // 2: bad stop bit followed by a held-low line, then a clean frame
    ferr0 = ferr_pulses;
    send_frame(8'h55, 1'b0);
    repeat (40) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t2_ferr_one_pulse", ferr_pulses - ferr0, 1);
    check("t2_fill_empty", fill, 0);
    send_good(8'h81);
    wait_drain("t2");
    check("t2_ferr_total", ferr_pulses - ferr0, 1);

    // 3: short low glitch on an idle line
    ferr0 = ferr_pulses;
    @(posedge clk); #1 rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    check("t3_fill", fill, 0);
    check("t3_valid", m_valid, 0);
    check("t3_no_ferr", ferr_pulses - ferr0, 0);

    // 4: fill to the RTS threshold, then to full
    @(posedge clk); #1 m_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_good(8'(i));
    send_expect(8'h0B, 1'b0);
    fork
      send_frame(8'h0B, 1'b1);
      begin
        repeat (PUSH_EDGE + 1) @(posedge clk);
        @(negedge clk);
        check("t4_fill12", fill, 12);
        check("t4_rts_lag", rts, 0);
        @(negedge clk);
        check("t4_rts_high", rts, 1);
      end
    join
    for (int i = 12; i < 16; i++) send_good(8'(i));
    @(negedge clk);
    check("t4_fill16", fill, 16);
    check("t4_no_overrun", overrun, 0);
    check("t4_rts_full", rts, 1);

    // 5: full FIFO, consumer ready only for the push cycle
    send_expect(8'h40, 1'b1);
    fork
      send_frame(8'h40, 1'b1);
      begin
        repeat (PUSH_EDGE) @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
      end
    join
    @(negedge clk);
    check("t5_fill16", fill, 16);
    check("t5_no_overrun", overrun, exp_overrun);

    // 4 (cont.): a byte into a full FIFO is dropped and overrun sticks
    send_good(8'h10);
    @(negedge clk);
    check("t4_overrun", overrun, exp_overrun);
    check("t4_fill_after_drop", fill, 16);

    // Drain one byte per cycle; rts follows the previous cycle's fill.
    @(posedge clk); #1 m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      int prev;
      prev = (i == 0) ? DEPTH : DEPTH - i + 1;
      @(negedge clk);
      check("t4_drain_fill", fill, DEPTH - i);
      check("t4_drain_rts", rts, prev >= THRESH);
    end
    @(negedge clk);
    check("t4_empty_fill", fill, 0);
    check("t4_empty_valid", m_valid, 0);
    check("t4_rts_low", rts, 0);
    check("t4_all_seen", exp_q.size(), 0);

    // 6: reset during data bit 4 with bytes buffered
    @(posedge clk); #1 m_ready = 1'b0;
    send_good(8'h21);
    send_good(8'h22);
    send_good(8'h23);
    @(negedge clk);
    check("t6_fill3", fill, 3);
    ferr0 = ferr_pulses;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (88) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        exp_overrun = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_fill0", fill, 0);
        check("t6_valid0", m_valid, 0);
        check("t6_data0", m_data, 8'h00);
        check("t6_rts_reset", rts, 1);
        check("t6_overrun0", overrun, exp_overrun);
        @(negedge clk);
        check("t6_rts_release", rts, 0);
      end
    join
    @(posedge clk); #1 m_ready = 1'b1;
    send_good(8'h12);
    wait_drain("t6");
    check("t6_no_ferr", ferr_pulses - ferr0, 0);

    // Random bytes, random gaps, random consumer back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rb = 8'($urandom);
          send_good(rb);
          repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain("rand");
    @(negedge clk);
    check("rand_fill", fill, 0);
    check("rand_overrun", overrun, exp_overrun);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "simulation timeout");
  end

endmodule
